l1_ahb_arbiter_nport: RTL and testbench

//  Output-stage arbiter for the L1 AHB matrix. It selects which of NUM_PORTS input

---
 rtl/l1_ahb_arbiter_nport.sv | 142 ++++++++++++++
 tb/tb_l1_ahb_arbiter_nport.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/l1_ahb_arbiter_nport.sv
// Output-stage arbiter for one L1 AHB matrix output: picks the input stage that drives
// the shared slave port, never splitting fixed-length bursts or locked sequences.
module l1_ahb_arbiter_nport #(
    parameter  int NUM_PORTS = 4,
    parameter  int ARB_MODE  = 0,
    localparam int PORT_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [3:0]           burst_cnt;
    logic [3:0]           next_cnt;
    logic                 next_hold;
    logic [PORT_W-1:0]    last_served;
    logic [NUM_PORTS-1:0] eff_req;
    logic [PORT_W-1:0]    sel_next;
    logic                 no_port_next;
    logic [PORT_W-1:0]    win;
    logic                 found;
    logic [PORT_W:0]      rr_sum;
    logic [PORT_W-1:0]    rr_pick;

    // Beat counter tracks the remaining SEQ beats of a fixed-length burst.
    always_comb begin
        next_cnt  = burst_cnt;
        next_hold = burst_hold;
        if (!HREADYM) begin
            next_cnt  = burst_cnt;
            next_hold = burst_hold;
        end else if (!HSELM) begin
            next_cnt  = 4'd0;
            next_hold = 1'b0;
        end else begin
            case (HTRANSM)
                TR_NONSEQ: begin
                    case (HBURSTM)
                        3'b110, 3'b111: begin next_cnt = 4'd15; next_hold = 1'b1; end
                        3'b100, 3'b101: begin next_cnt = 4'd7;  next_hold = 1'b1; end
                        3'b010, 3'b011: begin next_cnt = 4'd3;  next_hold = 1'b1; end
                        default:        begin next_cnt = 4'd0;  next_hold = 1'b0; end
                    endcase
                end
                TR_SEQ: begin
                    next_cnt = burst_cnt - 4'd1;
                    if (burst_cnt == 4'd1)
                        next_hold = 1'b0;
                end
                TR_BUSY: begin
                    next_cnt  = burst_cnt;
                    next_hold = burst_hold;
                end
                default: begin
                    next_cnt  = 4'd0;
                    next_hold = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        eff_req = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            eff_req[i] = req_port[i] |
                         ((addr_in_port == PORT_W'(i)) & HSELM & (HTRANSM != TR_IDLE));
    end

    always_comb begin
        win     = '0;
        found   = 1'b0;
        rr_sum  = '0;
        rr_pick = '0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--)
                if (eff_req[i])
                    win = PORT_W'(i);
        end else begin
            // Search begins one past the last served port and wraps.
            for (int k = 1; k <= NUM_PORTS; k++) begin
                rr_sum = {1'b0, last_served} + (PORT_W+1)'(k);
                if (rr_sum >= (PORT_W+1)'(NUM_PORTS))
                    rr_sum = rr_sum - (PORT_W+1)'(NUM_PORTS);
                rr_pick = rr_sum[PORT_W-1:0];
                if (!found && eff_req[rr_pick]) begin
                    found = 1'b1;
                    win   = rr_pick;
                end
            end
        end
    end

    always_comb begin
        sel_next     = addr_in_port;
        no_port_next = no_port;
        if (HMASTLOCKM || next_hold) begin
            sel_next     = addr_in_port;
            no_port_next = no_port;
        end else if (|eff_req) begin
            sel_next     = win;
            no_port_next = 1'b0;
        end else if (HSELM) begin
            no_port_next = 1'b0;
        end else begin
            no_port_next = 1'b1;
        end
    end

    // A grant out of the idle (no_port) state counts as a move for round-robin rotation.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            burst_cnt    <= 4'd0;
            burst_hold   <= 1'b0;
            addr_in_port <= '0;
            no_port      <= 1'b1;
            last_served  <= PORT_W'(NUM_PORTS - 1);
        end else begin
            burst_cnt  <= next_cnt;
            burst_hold <= next_hold;
            if (HREADYM) begin
                addr_in_port <= sel_next;
                no_port      <= no_port_next;
                if (!no_port_next && (no_port || (sel_next != addr_in_port)))
                    last_served <= sel_next;
            end
        end
    end

endmodule

// File: tb/tb_l1_ahb_arbiter_nport.sv
// Directed bench for l1_ahb_arbiter_nport: one fixed-priority and one round-robin
// instance share stimulus; each section checks the instance it targets.
module tb_l1_ahb_arbiter_nport;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;

    logic [1:0] f_addr, r_addr;
    logic       f_no_port, r_no_port;
    logic       f_hold, r_hold;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;

    always #5 HCLK = ~HCLK;

    l1_ahb_arbiter_nport #(.NUM_PORTS(4), .ARB_MODE(0)) u_fixed (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(f_addr), .no_port(f_no_port), .burst_hold(f_hold)
    );

    l1_ahb_arbiter_nport #(.NUM_PORTS(4), .ARB_MODE(1)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(r_addr), .no_port(r_no_port), .burst_hold(r_hold)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic sel, input logic [1:0] tr,
                         input logic [2:0] bu, input logic lk);
        req_port   = r;
        HSELM      = sel;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
    endtask

    initial begin
        HRESETn = 1'b0;
        HREADYM = 1'b0;
        drive(4'hF, 1'b0, IDLE, SINGLE, 1'b0);

        // reset for two clocks, HREADYM low
        step();
        step();
        check("rst_no_port", 32'(f_no_port), 1);
        check("rst_addr", 32'(f_addr), 0);
        check("rst_hold", 32'(f_hold), 0);
        check("rst_rr_no_port", 32'(r_no_port), 1);

        // fixed priority
        HRESETn = 1'b1;
        HREADYM = 1'b1;
        drive(4'b1010, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        check("fix_addr_1", 32'(f_addr), 1);
        check("fix_no_port_0", 32'(f_no_port), 0);
        drive(4'b1000, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        check("fix_addr_3", 32'(f_addr), 3);

        // reset pulse between edges is ignored
        #2 HRESETn = 1'b0;
        #2 HRESETn = 1'b1;
        step();
        check("pulse_addr", 32'(f_addr), 3);
        check("pulse_no_port", 32'(f_no_port), 0);

        // lock holds port 3 through IDLEs
        drive(4'b0001, 1'b1, IDLE, SINGLE, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("lock_hold_addr", 32'(f_addr), 3);
        end
        HMASTLOCKM = 1'b0;
        step();
        check("lock_drop_addr", 32'(f_addr), 0);

        // no request: no_port rises only on a ready edge
        drive(4'b0000, 1'b0, IDLE, SINGLE, 1'b0);
        HREADYM = 1'b0;
        step();
        check("noreq_wait_no_port", 32'(f_no_port), 0);
        HREADYM = 1'b1;
        step();
        check("noreq_no_port", 32'(f_no_port), 1);
        check("noreq_addr", 32'(f_addr), 0);
        HSELM = 1'b1;
        step();
        check("hsel_keep_no_port", 32'(f_no_port), 0);
        check("hsel_keep_addr", 32'(f_addr), 0);

        // INCR8 from port 2 with port 0 requesting
        drive(4'b0100, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        check("burst_grant2", 32'(f_addr), 2);
        drive(4'b0101, 1'b1, NONSEQ, INCR8, 1'b0);
        step();
        check("burst_ns_addr", 32'(f_addr), 2);
        check("burst_ns_hold", 32'(f_hold), 1);
        HTRANSM = SEQ;
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin
                HREADYM = 1'b0;
                step();
                check("burst_wait_addr", 32'(f_addr), 2);
                check("burst_wait_hold", 32'(f_hold), 1);
                HREADYM = 1'b1;
            end
            step();
            check("burst_seq_addr", 32'(f_addr), (k < 7) ? 2 : 0);
            check("burst_seq_hold", 32'(f_hold), (k < 7) ? 1 : 0);
        end

        // reset in the middle of an INCR4
        drive(4'b0100, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        check("mid_grant2", 32'(f_addr), 2);
        drive(4'b0100, 1'b1, NONSEQ, INCR4, 1'b0);
        step();
        check("mid_hold_set", 32'(f_hold), 1);
        HRESETn = 1'b0;
        HTRANSM = SEQ;
        step();
        check("mid_rst_hold", 32'(f_hold), 0);
        check("mid_rst_no_port", 32'(f_no_port), 1);
        check("mid_rst_addr", 32'(f_addr), 0);
        HRESETn = 1'b1;
        drive(4'b0010, 1'b1, SEQ, INCR4, 1'b0);
        step();
        check("mid_post_no_port", 32'(f_no_port), 0);
        check("mid_post_hold", 32'(f_hold), 0);

        // round robin, SINGLE NONSEQ every cycle, one wait state
        HRESETn = 1'b0;
        drive(4'hF, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        HRESETn = 1'b1;
        drive(4'hF, 1'b1, NONSEQ, SINGLE, 1'b0);
        step();
        check("rr_g0", 32'(r_addr), 0);
        check("rr_g0_no_port", 32'(r_no_port), 0);
        step();
        check("rr_g1", 32'(r_addr), 1);
        HREADYM = 1'b0;
        step();
        check("rr_wait", 32'(r_addr), 1);
        HREADYM = 1'b1;
        step();
        check("rr_g2", 32'(r_addr), 2);
        step();
        check("rr_g3", 32'(r_addr), 3);
        step();
        check("rr_g0_wrap", 32'(r_addr), 0);
        check("fix_stays0", 32'(f_addr), 0);
        req_port = 4'b0101;
        step();
        check("rr_sparse2", 32'(r_addr), 2);
        step();
        check("rr_sparse0", 32'(r_addr), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
